// File: rtl/dvp_cfg_pkg.sv
// Shared definitions for the DVP configuration master: AXI response codes,
// FSM state encoding and the DVP config block register map.
package dvp_cfg_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DVP_STATUS_ADDR   = 32'h4000_0000;
  localparam logic [31:0] SCALER_CONF_ADDR  = 32'h4000_0004;
  localparam logic [31:0] PXL_MEM_BASE_ADDR = 32'h4000_0008;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  // States in which the master is waiting on the AXI slave
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
           (s == ST_RD_REQ) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/dvp_config_master.sv
// Single-beat AXI4 master for configuration register writes and reads.
// One command at a time from the cmd port, one response on the rsp port.
// Optional: define DVP_CONFIG_MASTER_TIMEOUT_EN to abort stalled slave
// transactions after TIMEOUT_CYC cycles with a SLVERR response.
module dvp_config_master
  import dvp_cfg_pkg::*;
#(
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          ADDR_W       = 32,
  parameter int unsigned          MST_ID_W     = 5,
  parameter logic [MST_ID_W-1:0]  MST_ID       = '0,
  parameter int unsigned          TRANS_RESP_W = 2,
  parameter int unsigned          TIMEOUT_CYC  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wr_i,
  input  logic [ADDR_W-1:0]       cmd_addr_i,
  input  logic [DATA_W-1:0]       cmd_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_rdata_o,
  output logic [TRANS_RESP_W-1:0] rsp_resp_o,
  output logic [MST_ID_W-1:0]     m_awid_o,
  output logic [ADDR_W-1:0]       m_awaddr_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  output logic [DATA_W-1:0]       m_wdata_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  input  logic [TRANS_RESP_W-1:0] m_bresp_i,
  input  logic                    m_bvalid_i,
  output logic                    m_bready_o,
  output logic [MST_ID_W-1:0]     m_arid_o,
  output logic [ADDR_W-1:0]       m_araddr_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [MST_ID_W-1:0]     m_rid_i,
  input  logic [DATA_W-1:0]       m_rdata_i,
  input  logic [TRANS_RESP_W-1:0] m_rresp_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o
);

  // Elaboration-time sanity check on the timeout limit
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("dvp_config_master: TIMEOUT_CYC has to be nonzero");
  end

  state_t state_q, state_d;

  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    cmd_ready_d;
  logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                    rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_d;
  logic [TRANS_RESP_W-1:0] rsp_resp_d;

  logic accept_c, aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c, rsp_hs_c;
  logic timeout_c;

  assign accept_c = cmd_valid_i & cmd_ready_o;
  assign aw_hs_c  = m_awvalid_o & m_awready_i;
  assign w_hs_c   = m_wvalid_o & m_wready_i;
  assign b_hs_c   = m_bvalid_i & m_bready_o;
  assign ar_hs_c  = m_arvalid_o & m_arready_i;
  assign r_hs_c   = m_rvalid_i & m_rready_o;
  assign rsp_hs_c = rsp_valid_o & rsp_ready_i;

  assign m_awid_o   = MST_ID;
  assign m_arid_o   = MST_ID;
  assign m_awaddr_o = addr_q;
  assign m_araddr_o = addr_q;
  assign m_wdata_o  = wdata_q;

`ifdef DVP_CONFIG_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_q;

  // Cycles spent in the current slave-wait state; restarts on any state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!is_wait_state(state_q) || (state_d != state_q)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_c = is_wait_state(state_q) &&
                     (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = cmd_wr_i ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_WR_REQ: begin
        if (timeout_c) state_d = ST_RSP;
        else if ((aw_done_q | aw_hs_c) && (w_done_q | w_hs_c)) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (timeout_c || b_hs_c) state_d = ST_RSP;
      end
      ST_RD_REQ: begin
        if (timeout_c) state_d = ST_RSP;
        else if (ar_hs_c) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (timeout_c || r_hs_c) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_hs_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = m_awvalid_o;
    wvalid_d    = m_wvalid_o;
    bready_d    = m_bready_o;
    arvalid_d   = m_arvalid_o;
    rready_d    = m_rready_o;
    rsp_valid_d = rsp_valid_o;
    rsp_rdata_d = rsp_rdata_o;
    rsp_resp_d  = rsp_resp_o;
    cmd_ready_d = (state_d == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          if (cmd_wr_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (state_d == ST_WR_RESP) bready_d = 1'b1;
      end
      ST_WR_RESP: begin
        if (b_hs_c) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_bresp_i;
        end
      end
      ST_RD_REQ: begin
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (r_hs_c) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_rdata_i;
          rsp_resp_d  = (m_rid_i != MST_ID) ? TRANS_RESP_W'(RESP_SLVERR) : m_rresp_i;
        end
      end
      ST_RSP: begin
        if (rsp_hs_c) rsp_valid_d = 1'b0;
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase

    // Abort a stalled slave transaction
    if (timeout_c) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = TRANS_RESP_W'(RESP_SLVERR);
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_o <= 1'b0;
      m_awvalid_o <= 1'b0;
      m_wvalid_o  <= 1'b0;
      m_bready_o  <= 1'b0;
      m_arvalid_o <= 1'b0;
      m_rready_o  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_resp_o  <= '0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_o <= cmd_ready_d;
      m_awvalid_o <= awvalid_d;
      m_wvalid_o  <= wvalid_d;
      m_bready_o  <= bready_d;
      m_arvalid_o <= arvalid_d;
      m_rready_o  <= rready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_resp_o  <= rsp_resp_d;
    end
  end

endmodule

// File: doc/dvp_config_master.md
Name: dvp_config_master

Overview:
- Single-beat AXI4 master that issues configuration register writes and reads toward memory-mapped slaves such as the DVP config block (status 0x4000_0000, scaler 0x4000_0004, pixel base 0x4000_0008).
- Takes one command at a time from a local valid/ready command port.
- Drives AW/W/B or AR/R to completion, then returns the response on a local valid/ready response port.
- Sits between the boot/config sequencer and the AXI interconnect.

Parameters:
- DATA_W, 32, AXI data width and command write-data width.
- ADDR_W, 32, AXI address width.
- MST_ID_W, 5, AXI ID width.
- MST_ID, 5'd0, constant ID driven on awid/arid and expected back on rid.
- TRANS_RESP_W, 2, AXI response width.
- TIMEOUT_CYC, 256, wait-cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_wr_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_W  target address
- cmd_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_resp_o  out  TRANS_RESP_W  completion code
- m_awid_o  out  MST_ID_W
- m_awaddr_o  out  ADDR_W
- m_awvalid_o  out  1
- m_awready_i  in  1
- m_wdata_o  out  DATA_W
- m_wvalid_o  out  1
- m_wready_i  in  1
- m_bresp_i  in  TRANS_RESP_W
- m_bvalid_i  in  1
- m_bready_o  out  1
- m_arid_o  out  MST_ID_W
- m_araddr_o  out  ADDR_W
- m_arvalid_o  out  1
- m_arready_i  in  1
- m_rid_i  in  MST_ID_W
- m_rdata_i  in  DATA_W
- m_rresp_i  in  TRANS_RESP_W
- m_rvalid_i  in  1
- m_rready_o  out  1

Behaviour:
- Reset: clk, rst_n async active-low.
  - State IDLE; all valid/ready outputs 0; rsp_rdata_o = 0; rsp_resp_o = 0; latched addr/data = 0.
  - Reset mid-transaction aborts immediately. No response is produced.
- Registered outputs: m_awid_o and m_arid_o are constant MST_ID. All other outputs are registered.
- Command acceptance:
  - cmd_ready_o = (state == IDLE).
  - The handshake latches wr, addr and wdata.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - On accept with cmd_wr_i=1 → WR_REQ.
  - On accept with cmd_wr_i=0 → RD_REQ.
  - awvalid/wvalid (write) or arvalid (read) rise in the cycle after accept.
- WR_REQ:
  - AW and W are handshaked independently.
  - Each valid stays high until its own ready is sampled high, then drops the next cycle.
  - Accepting AW and W on the same cycle is allowed.
  - Address and data must not change while valid is high.
  - When both handshakes are done → WR_RESP with m_bready_o = 1.
- WR_RESP:
  - On m_bvalid_i & m_bready_o: capture bresp and set rsp_rdata_o = 0.
  - Drop bready and go to RSP.
- RD_REQ: arvalid is held until m_arready_i, then → RD_DATA with m_rready_o = 1.
- RD_DATA, on m_rvalid_i & m_rready_o:
  - Capture rdata and rresp.
  - If m_rid_i != MST_ID, force rsp_resp_o = 2'b10 (ID mismatch); rdata is still captured.
  - Drop rready and go to RSP.
- RSP:
  - rsp_valid_o = 1, with rsp_* stable, until rsp_ready_i.
  - Then → IDLE. A new command can be accepted the following cycle.
- Response codes: slave responses 2'b00 (OK) and 2'b11 (unmapped address) are passed through unchanged.
- Minimum latency, with zero-wait slave and sink: accept at T0, valid at T1, resp at T2, rsp_valid_o at T3.
- Concurrency: at most one outstanding transaction; AW/W never overlap with AR.

Optional Feature:
- Macro: DVP_CONFIG_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of at least $clog2(TIMEOUT_CYC+1) bits counts cycles spent in WR_REQ, WR_RESP, RD_REQ and RD_DATA. It clears on every state change.
  - On reaching TIMEOUT_CYC: deassert all AXI valid/ready outputs, set rsp_resp_o = 2'b10 and rsp_rdata_o = 0, then go to RSP.
- When undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared header/package dvp_cfg_pkg holds:
  - Response codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State encodings.
  - Register address constants: DVP_STATUS_ADDR, SCALER_CONF_ADDR, PXL_MEM_BASE_ADDR.
- No sub-module; a single FSM with the datapath registers.

Test Plan:
- Write 0x4000_0004 ← 0x0000_00A5, zero-wait slave → aw/w valid at T1, rsp_valid_o at T3, rsp_resp_o = 00, rsp_rdata_o = 0.
- awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles, single B accepted, rsp 00.
- Read 0x4000_0008 with slave returning 0x8000_0000 and rid = MST_ID → rsp_rdata_o = 0x8000_0000, rsp_resp_o = 00.
- Write 0x4000_0010 (unmapped), slave bresp = 11 → rsp_resp_o = 11.
- Read with rid = MST_ID+1 → rsp_resp_o = 10; rsp held while rsp_ready_i is low for 5 cycles; cmd_ready_o stays 0 until the rsp handshake.
- rst_n asserted during WR_RESP → all valids/readies 0 immediately, cmd_ready_o = 1 after release. With timeout enabled, a slave that never asserts bvalid gives rsp_resp_o = 10 after TIMEOUT_CYC cycles.
